// File: rtl/tdm_transmit_if.sv
// Sample-frame handshake between a frame producer and the TDM transmitter.
// The producer offers a full frame; the transmitter takes it when its holding register is empty.
interface tdm_transmit_if #(
    parameter int SLOTS     = 4,
    parameter int BIT_WIDTH = 24
);
    logic [SLOTS*BIT_WIDTH-1:0] sample_in;
    logic                       sample_valid_in;
    logic                       sample_ready_out;

    modport master (
        output sample_in,
        output sample_valid_in,
        input  sample_ready_out
    );

    modport slave (
        input  sample_in,
        input  sample_valid_in,
        output sample_ready_out
    );
endinterface

// File: rtl/tdm_transmit.sv
// TDM serial transmitter: one ws cycle, then SLOTS slots of SLOT_CYCLES bits,
// MSB first, zero padded, with an optional idle gap before the next frame.
module tdm_transmit #(
    parameter int BIT_WIDTH   = 24,
    parameter int SLOTS       = 4,
    parameter int SLOT_CYCLES = 32,
    parameter int GAP_CYCLES  = 0
) (
    input  logic          sck,
    input  logic          rst_n_in,
    input  logic          enable_in,
    tdm_transmit_if.slave smp,
    output logic          ws_out,
    output logic          sd_out,
    output logic [2:0]    slot_out,
    output logic          frame_start_out,
    output logic          underflow_out
);

    localparam int FW = SLOTS * BIT_WIDTH;
    localparam int CW = $clog2(SLOT_CYCLES);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [CW-1:0] B_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] B_DATA = CW'(BIT_WIDTH);
    localparam logic [2:0]    S_LAST = 3'(SLOTS - 1);
    localparam logic [GW-1:0] G_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        DATA,
        GAP
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   bcnt_q, bcnt_d;
    logic [2:0]      slot_q, slot_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [FW-1:0]   hold_q, hold_d;
    logic            hold_full_q, hold_full_d;
    logic [FW-1:0]   shift_q, shift_d;
    logic            ws_q, ws_d;
    logic            sd_q, sd_d;
    logic [2:0]      slot_out_q, slot_out_d;
    logic            uf_q, uf_d;

    logic            boundary;
    logic            sync_entry;
    logic            emit;
    logic [FW-1:0]   hold_ordered;

    // Slot 0 goes to the top so the shift buffer always emits its MSB.
    always_comb begin
        hold_ordered = '0;
        for (int k = 0; k < SLOTS; k++) begin
            hold_ordered[(SLOTS-1-k)*BIT_WIDTH +: BIT_WIDTH] =
                hold_q[k*BIT_WIDTH +: BIT_WIDTH];
        end
    end

    always_comb begin
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        slot_d   = slot_q;
        gap_d    = gap_q;
        boundary = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable_in) state_d = SYNC;
            end
            SYNC: begin
                state_d = DATA;
                bcnt_d  = '0;
                slot_d  = '0;
            end
            DATA: begin
                if (bcnt_q == B_LAST) begin
                    bcnt_d = '0;
                    if (slot_q == S_LAST) begin
                        slot_d = '0;
                        if (GAP_CYCLES > 0) begin
                            state_d = GAP;
                            gap_d   = '0;
                        end else begin
                            boundary = 1'b1;
                        end
                    end else begin
                        slot_d = slot_q + 3'd1;
                    end
                end else begin
                    bcnt_d = bcnt_q + CW'(1);
                end
            end
            GAP: begin
                if (gap_q == G_LAST) boundary = 1'b1;
                else gap_d = gap_q + GW'(1);
            end
            default: state_d = IDLE;
        endcase
        if (boundary) state_d = enable_in ? SYNC : IDLE;
    end

    // Outputs are computed for the state being entered so they can be registered.
    always_comb begin
        sync_entry  = (state_d == SYNC);
        emit        = (state_d == DATA) && (bcnt_d < B_DATA);
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        if (sync_entry) begin
            shift_d     = hold_full_q ? hold_ordered : '0;
            hold_full_d = 1'b0;
        end else if (emit) begin
            shift_d = shift_q << 1;
        end
        // No bypass: a frame accepted on a SYNC edge waits for the next frame.
        if (smp.sample_valid_in && !hold_full_q) begin
            hold_d      = smp.sample_in;
            hold_full_d = 1'b1;
        end
        ws_d       = sync_entry;
        uf_d       = sync_entry && !hold_full_q;
        sd_d       = emit ? shift_q[FW-1] : 1'b0;
        slot_out_d = (state_d == DATA) ? slot_d : 3'd0;
    end

    always_ff @(posedge sck or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            bcnt_q      <= '0;
            slot_q      <= '0;
            gap_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            ws_q        <= 1'b0;
            sd_q        <= 1'b0;
            slot_out_q  <= '0;
            uf_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            slot_q      <= slot_d;
            gap_q       <= gap_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            ws_q        <= ws_d;
            sd_q        <= sd_d;
            slot_out_q  <= slot_out_d;
            uf_q        <= uf_d;
        end
    end

    assign smp.sample_ready_out = !hold_full_q;
    assign ws_out               = ws_q;
    assign sd_out               = sd_q;
    assign slot_out             = slot_out_q;
    assign frame_start_out      = ws_q;
    assign underflow_out        = uf_q;

endmodule

// File: tb/tb_tdm_transmit.sv
// Bench for tdm_transmit: a frame-level reference model checks every cycle of
// two instances (no gap and a 3-cycle gap), plus directed corner sequences.
module tb_tdm_transmit;

    logic        sck = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        valid = 1'b0;
    logic [95:0] sample = '0;

    always #5 sck = ~sck;

    tdm_transmit_if #(.SLOTS(4), .BIT_WIDTH(24)) sif0 ();
    tdm_transmit_if #(.SLOTS(4), .BIT_WIDTH(24)) sif1 ();

    assign sif0.sample_in       = sample;
    assign sif0.sample_valid_in = valid;
    assign sif1.sample_in       = sample;
    assign sif1.sample_valid_in = valid;

    logic       ws0, sd0, fs0, uf0;
    logic       ws1, sd1, fs1, uf1;
    logic [2:0] slot0, slot1;

    tdm_transmit #(.BIT_WIDTH(24), .SLOTS(4), .SLOT_CYCLES(32), .GAP_CYCLES(0)) dut0 (
        .sck(sck), .rst_n_in(rst_n), .enable_in(enable), .smp(sif0),
        .ws_out(ws0), .sd_out(sd0), .slot_out(slot0),
        .frame_start_out(fs0), .underflow_out(uf0)
    );

    tdm_transmit #(.BIT_WIDTH(24), .SLOTS(4), .SLOT_CYCLES(32), .GAP_CYCLES(3)) dut1 (
        .sck(sck), .rst_n_in(rst_n), .enable_in(enable), .smp(sif1),
        .ws_out(ws1), .sd_out(sd1), .slot_out(slot1),
        .frame_start_out(fs1), .underflow_out(uf1)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    // Reference model: each frame is expanded into its per-cycle output tuples
    // {ws, sd, slot[2:0], frame_start, underflow} when it starts.
    logic [6:0]  m_buf [2][256];
    int          m_len [2];
    int          m_rd [2];
    logic        m_full [2];
    logic [95:0] m_hold [2];
    logic [6:0]  m_exp [2];
    int          gapv [2];

    bit chk_period = 0;
    int last0 = -1;
    int last1 = -1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mclear(input int m);
        m_len[m] = 0;
        m_rd[m] = 0;
        m_full[m] = 1'b0;
        m_hold[m] = '0;
        m_exp[m] = '0;
    endtask

    task automatic mstep(input int m);
        logic        xfer;
        logic [95:0] d;
        logic [95:0] tmp;
        logic        u, bv;
        int          s, b;
        if (!rst_n) begin
            mclear(m);
            return;
        end
        xfer = valid && !m_full[m];
        if (m_rd[m] >= m_len[m]) begin
            m_rd[m] = 0;
            m_len[m] = 0;
            if (enable) begin
                d = m_full[m] ? m_hold[m] : '0;
                u = !m_full[m];
                m_full[m] = 1'b0;
                m_buf[m][0] = {1'b1, 1'b0, 3'd0, 1'b1, u};
                m_len[m] = 1;
                for (int i = 0; i < 4 * 32; i++) begin
                    s = i / 32;
                    b = i % 32;
                    bv = 1'b0;
                    if (b < 24) begin
                        tmp = d >> (s * 24 + 23 - b);
                        bv = tmp[0];
                    end
                    m_buf[m][m_len[m]] = {1'b0, bv, 3'(s), 2'b00};
                    m_len[m]++;
                end
                for (int g = 0; g < gapv[m]; g++) begin
                    m_buf[m][m_len[m]] = '0;
                    m_len[m]++;
                end
            end
        end
        if (m_rd[m] < m_len[m]) begin
            m_exp[m] = m_buf[m][m_rd[m]];
            m_rd[m]++;
        end else begin
            m_exp[m] = '0;
        end
        if (xfer) begin
            m_hold[m] = sample;
            m_full[m] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge sck);
        mstep(0);
        mstep(1);
        #1;
        cyc++;
        chk("stream0", {ws0, sd0, slot0, fs0, uf0, sif0.sample_ready_out}, {m_exp[0], !m_full[0]});
        chk("stream1", {ws1, sd1, slot1, fs1, uf1, sif1.sample_ready_out}, {m_exp[1], !m_full[1]});
        if (chk_period) begin
            if (ws0) begin
                if (last0 >= 0) chk("period0", cyc - last0, 129);
                last0 = cyc;
            end
            if (ws1) begin
                if (last1 >= 0) chk("period1", cyc - last1, 132);
                last1 = cyc;
            end
        end
    endtask

    function automatic logic [95:0] rnd_frame();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    task automatic wait_ws0(input string nm, input int bound);
        bit found;
        found = 0;
        for (int k = 0; k < bound; k++) begin
            tick();
            if (ws0) begin
                found = 1;
                break;
            end
        end
        chk(nm, found, 1);
    endtask

    task automatic wait_pos0(input string nm, input int rd, input int bound);
        bit found;
        found = 0;
        for (int k = 0; k < bound; k++) begin
            tick();
            if (m_rd[0] == rd && m_len[0] > 0) begin
                found = 1;
                break;
            end
        end
        chk(nm, found, 1);
    endtask

    typedef struct {
        string nm;
        int    idx;
        logic  exp;
    } vec_t;

    vec_t        tv [14];
    logic        cap [128];
    logic [2:0]  cap_slot [128];
    logic [95:0] v1;
    logic [95:0] tmp;
    logic [23:0] dec;
    int          cnt_a, cnt_b;
    bit          ok;

    initial begin
        gapv[0] = 0;
        gapv[1] = 3;
        mclear(0);
        mclear(1);

        v1 = {24'h123456, 24'h800000, 24'h000001, 24'hA5A5A5};
        tv[0]  = '{"s0_b0", 0, 1'b1};
        tv[1]  = '{"s0_b1", 1, 1'b0};
        tv[2]  = '{"s0_b2", 2, 1'b1};
        tv[3]  = '{"s0_b3", 3, 1'b0};
        tv[4]  = '{"s0_b4", 4, 1'b0};
        tv[5]  = '{"s0_b5", 5, 1'b1};
        tv[6]  = '{"s0_b6", 6, 1'b0};
        tv[7]  = '{"s0_b7", 7, 1'b1};
        tv[8]  = '{"s0_pad24", 24, 1'b0};
        tv[9]  = '{"s0_pad31", 31, 1'b0};
        tv[10] = '{"s1_msb", 32, 1'b0};
        tv[11] = '{"s1_lsb", 55, 1'b1};
        tv[12] = '{"s2_msb", 64, 1'b1};
        tv[13] = '{"s2_b1", 65, 1'b0};

        // Reset state
        for (int k = 0; k < 3; k++) tick();
        chk("reset0", {ws0, sd0, slot0, fs0, uf0, sif0.sample_ready_out}, 8'h01);
        chk("reset1", {ws1, sd1, slot1, fs1, uf1, sif1.sample_ready_out}, 8'h01);
        rst_n = 1'b1;

        // Test 1: one known frame
        sample = v1;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        enable = 1'b1;
        wait_ws0("t1_ws", 20);
        chk("t1_no_uf", uf0, 0);
        for (int i = 0; i < 128; i++) begin
            tick();
            if (i == 0) chk("t1_ws_one_cycle", ws0, 0);
            cap[i] = sd0;
            cap_slot[i] = slot0;
        end
        for (int i = 0; i < 14; i++) chk({"t1_", tv[i].nm}, cap[tv[i].idx], tv[i].exp);
        chk("t1_slot3_idx", cap_slot[96], 3);
        for (int s = 0; s < 4; s++) begin
            dec = '0;
            for (int b = 0; b < 24; b++) dec = {dec[22:0], cap[s*32+b]};
            tmp = v1 >> (s * 24);
            chk($sformatf("t1_decode_slot%0d", s), dec, tmp[23:0]);
        end

        // Test 2: continuous valid, periods checked for both instances
        valid = 1'b1;
        chk_period = 1;
        for (int k = 0; k < 420; k++) begin
            sample = rnd_frame();
            tick();
        end
        chk_period = 0;
        chk("t2_period_seen0", last0 >= 0, 1);
        chk("t2_period_seen1", last1 >= 0, 1);

        // Test 3: no valid, underflow frames
        valid = 1'b0;
        cnt_a = 0;
        cnt_b = 0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (uf0) cnt_a++;
            if (uf0 != fs0 && uf0) cnt_b++;
        end
        chk("t3_uf_seen", cnt_a >= 1, 1);
        chk("t3_uf_with_fs", cnt_b, 0);

        // Test 4: valid on the SYNC edge with hold empty
        ok = 0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (m_len[0] > 0 && m_rd[0] == m_len[0] && !m_full[0]) begin
                ok = 1;
                break;
            end
        end
        chk("t4_reach_end", ok, 1);
        sample = rnd_frame();
        valid = 1'b1;
        tick();
        valid = 1'b0;
        chk("t4_sync_uf", {ws0, uf0, sif0.sample_ready_out}, 3'b110);
        wait_ws0("t4_next_ws", 200);
        chk("t4_next_not_uf", uf0, 0);

        // Test 5: drop enable at slot 1 bit 5 with a held frame
        sample = rnd_frame();
        valid = 1'b1;
        tick();
        valid = 1'b0;
        wait_pos0("t5_reach_pos", 1 + 32 + 5 + 1, 300);
        enable = 1'b0;
        cnt_a = 0;
        for (int k = 0; k < 140; k++) begin
            tick();
            if (ws0) cnt_a++;
        end
        chk("t5_no_ws", cnt_a, 0);
        chk("t5_hold_kept", sif0.sample_ready_out, 0);
        enable = 1'b1;
        wait_ws0("t5_reenable_ws", 5);
        chk("t5_held_sent", uf0, 0);

        // Test 6: asynchronous reset at slot 2 bit 10
        wait_pos0("t6_reach_pos", 1 + 64 + 10 + 1, 300);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_async0", {ws0, sd0, slot0, fs0, uf0, sif0.sample_ready_out}, 8'h01);
        chk("t6_async1", {ws1, sd1, slot1, fs1, uf1, sif1.sample_ready_out}, 8'h01);
        mclear(0);
        mclear(1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_uf_after_reset", {ws0, uf0}, 2'b11);

        // Randomised run
        for (int k = 0; k < 3000; k++) begin
            valid = ($urandom_range(0, 2) == 0);
            sample = rnd_frame();
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/tdm_transmit.md
Name: tdm_transmit

Overview:
- TDM serial transmitter; the source side of the beamforming mic-array TDM link.
- Accepts one frame of SLOTS parallel samples through a valid/ready handshake.
- Serialises the frame MSB-first onto sd_out with a one-cycle ws_out frame marker.
- Framing matches the TDM receiver: one ws cycle, then SLOTS slots of SLOT_CYCLES bits each. Used to drive mic-array emulation and loopback testing.

Parameters:
- BIT_WIDTH, 24, sample width in bits (must be < SLOT_CYCLES).
- SLOTS, 4, slots per frame.
- SLOT_CYCLES, 32, sck cycles per slot; data bits, then zero padding.
- GAP_CYCLES, 0, idle cycles after the last slot before the next ws cycle.

Ports:
- sck  input  1  serial clock; all logic on posedge.
- rst_n_in  input  1  asynchronous active-low reset.
- enable_in  input  1  run frames while high; sampled only at frame boundaries.
- sample_in  input  SLOTS*BIT_WIDTH  frame samples; slot k occupies bits [k*BIT_WIDTH +: BIT_WIDTH].
- sample_valid_in  input  1  sample_in valid.
- sample_ready_out  output  1  holding register empty; equals !hold_full, combinational.
- ws_out  output  1  registered word select; high for exactly one cycle per frame.
- sd_out  output  1  registered serial data.
- slot_out  output  3  index of the slot currently on sd_out; 0 outside DATA.
- frame_start_out  output  1  one-cycle pulse, coincident with ws_out.
- underflow_out  output  1  one-cycle pulse, coincident with a ws_out that had no frame available.

Behaviour:
- Reset (async, rst_n_in=0):
  - state=IDLE; ws_out, sd_out, slot_out, frame_start_out, underflow_out = 0.
  - hold_full=0, so sample_ready_out=1.
  - Shift buffer and all counters = 0.
  - Asserting reset mid-frame aborts the frame immediately and discards any held frame.
- Input handshake:
  - Transfer occurs when sample_valid_in && sample_ready_out at a posedge.
  - On transfer: sample_in is copied to the holding register and hold_full is set.
  - hold_full clears only when the frame-start logic consumes the held frame.
  - No bypass: a frame accepted on the same edge as a SYNC entry is not used by that frame.
- States:
  - IDLE:
    - Outputs 0.
    - enable_in=1 -> SYNC next cycle.
  - SYNC (1 cycle):
    - ws_out=1, frame_start_out=1, sd_out=0.
    - If hold_full at entry: load the shift buffer from the holding register and clear hold_full.
    - Otherwise: load zeros and pulse underflow_out=1.
    - Next state: DATA with bit counter=0, slot=0.
  - DATA:
    - ws_out=0.
    - Bit counter b=0..SLOT_CYCLES-1.
    - b<BIT_WIDTH: sd_out = bit (BIT_WIDTH-1-b) of the current slot's sample (MSB first).
    - b>=BIT_WIDTH: sd_out=0.
    - At b=SLOT_CYCLES-1: b wraps to 0 and slot increments.
    - After the last bit of slot SLOTS-1: -> GAP if GAP_CYCLES>0, else the frame boundary.
  - GAP:
    - Outputs 0 for GAP_CYCLES cycles, then the frame boundary.
  - Frame boundary: enable_in=1 -> SYNC; else -> IDLE.
  - Deasserting enable_in mid-frame never truncates a frame.
- Timing:
  - All outputs are registered and change on posedge.
  - A receiver sampling on the next posedge sees ws=1 and then exactly SLOTS*SLOT_CYCLES data bits.
  - Frame period = 1 + SLOTS*SLOT_CYCLES + GAP_CYCLES cycles (129 at defaults).
  - Consecutive frames run back-to-back with no extra cycles.
- Latency:
  - sd_out carries the MSB of slot 0 one cycle after ws_out.
  - A held frame is transmitted at the next SYNC.
- Widths:
  - Bit counter is clog2(SLOT_CYCLES) bits.
  - Gap counter is clog2(GAP_CYCLES+1) bits.
  - slot_out is fixed at 3 bits, so SLOTS<=8.

Test Plan:
1. Reset, enable_in=1, then one frame with slots {24'hA5A5A5, 24'h000001, 24'h800000, 24'h123456}:
   - ws_out high 1 cycle.
   - Next 24 cycles on sd_out read 1010_0101... (A5A5A5), then 8 zeros.
   - Slot 1 ends with LSB=1 at cycle 24 of its slot.
   - Slot 3 decodes to 24'h123456.
   - Looped into the TDM receiver, this yields 4 audio_valid pulses with matching values.
2. Continuous valid over 3 frames at defaults:
   - ws_out pulses exactly 129 cycles apart.
   - sample_ready_out drops after each accept and rises on each SYNC.
   - No underflow.
3. enable_in=1 with no sample_valid_in:
   - underflow_out and frame_start_out pulse together.
   - All 128 data bits are 0.
4. Assert sample_valid_in on the SYNC edge with hold_full=0:
   - Current frame is underflow (zeros).
   - The accepted frame is sent in the following frame.
5. Drop enable_in at slot 1, bit 5:
   - Frame completes all 128 data cycles, then IDLE with ws_out=0.
   - Held frame is retained and sent on re-enable.
6. Assert rst_n_in low at slot 2, bit 10 (asynchronously, between edges):
   - All outputs are 0 immediately.
   - sample_ready_out=1.
   - After release with enable_in=1, the next SYNC is an underflow frame.
7. GAP_CYCLES=3: frame period is 132 cycles, and sd_out=0, ws_out=0 during the gap.
